mem_arbiter: RTL and testbench

Shares the single backing-memory port (`mem_req_cmd` / `mem_req_data` / `mem_resp`) between `NCLIENTS` requesters, e.g. the tag cache and an uncached bypass path. It sits between the requesters' memory interfaces and the memory controller. Commands are granted round-robin, and a write's data beats stay locked to the granted requester until the burst completes. Response tags are extended with the client index on the way out and stripped on return, so each response is routed back to the requester that issued the command.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_rr_picker.sv | 30 +++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM state encoding,
// default widths, and the packing helper for the extended memory tag.
package mem_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WDATA = 1'b1
  } arb_state_t;

  localparam int DEF_NCLIENTS   = 2;
  localparam int DEF_ADDR_W     = 26;
  localparam int DEF_TAG_W      = 5;
  localparam int DEF_DATA_W     = 128;
  localparam int DEF_DATA_BEATS = 4;

  // Places the client id directly above the client tag; caller truncates to MEM_TAG_W.
  function automatic logic [31:0] mem_tag_pack(input logic [31:0] id, input logic [31:0] tag,
                                               input int tag_w);
    return (id << tag_w) | tag;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational rotate-priority encoder. Returns the first set request
// at or after ptr, wrapping past N-1 back to 0.
module rr_picker #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  int idx;

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt_idx = IW'(idx);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory command/data/response port among NCLIENTS requesters.
// Build option MEM_ARBITER_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NCLIENTS   = DEF_NCLIENTS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int TAG_W      = DEF_TAG_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DATA_BEATS = DEF_DATA_BEATS,
  localparam int ID_W      = $clog2(NCLIENTS),
  localparam int MEM_TAG_W = TAG_W + ID_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NCLIENTS-1:0]        cl_cmd_valid,
  output logic [NCLIENTS-1:0]        cl_cmd_ready,
  input  logic [NCLIENTS*ADDR_W-1:0] cl_cmd_addr,
  input  logic [NCLIENTS*TAG_W-1:0]  cl_cmd_tag,
  input  logic [NCLIENTS-1:0]        cl_cmd_rw,
  input  logic [NCLIENTS-1:0]        cl_data_valid,
  output logic [NCLIENTS-1:0]        cl_data_ready,
  input  logic [NCLIENTS*DATA_W-1:0] cl_data_data,
  output logic [NCLIENTS-1:0]        cl_resp_valid,
  output logic [DATA_W-1:0]          cl_resp_data,
  output logic [TAG_W-1:0]           cl_resp_tag,
  output logic                       mem_cmd_valid,
  input  logic                       mem_cmd_ready,
  output logic [ADDR_W-1:0]          mem_cmd_addr,
  output logic [MEM_TAG_W-1:0]       mem_cmd_tag,
  output logic                       mem_cmd_rw,
  output logic                       mem_data_valid,
  input  logic                       mem_data_ready,
  output logic [DATA_W-1:0]          mem_data_data,
  input  logic                       mem_resp_valid,
  input  logic [DATA_W-1:0]          mem_resp_data,
  input  logic [MEM_TAG_W-1:0]       mem_resp_tag,
  output logic                       resp_err,
  output logic                       o_dbg_state,
  output logic [ID_W-1:0]            o_dbg_rr_ptr
);

  localparam int BW = $clog2(DATA_BEATS + 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the source holds valid and payload until then, and ready never depends on a later cycle.

  arb_state_t      r_state, w_state_nxt;
  logic [ID_W-1:0] r_rr_ptr, r_owner, w_pick_ptr, w_win_idx, w_rr_nxt, w_resp_id;
  logic [BW-1:0]   r_beat_cnt;
  logic            r_resp_err, w_win_any, w_win_rw, w_cmd_fire, w_data_fire, w_id_ok;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
  assign w_pick_ptr = '0;
`else
  assign w_pick_ptr = r_rr_ptr;
`endif

  rr_picker #(.N(NCLIENTS)) u_picker (
    .req     (cl_cmd_valid),
    .ptr     (w_pick_ptr),
    .gnt_idx (w_win_idx),
    .gnt_any (w_win_any)
  );

  assign w_win_rw     = cl_cmd_rw[w_win_idx];
  assign mem_cmd_addr = cl_cmd_addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
  assign mem_cmd_tag  = MEM_TAG_W'(mem_tag_pack(32'(w_win_idx),
                          32'(cl_cmd_tag[int'(w_win_idx)*TAG_W +: TAG_W]), TAG_W));
  assign mem_cmd_rw    = w_win_rw;
  assign mem_data_data = cl_data_data[int'(r_owner)*DATA_W +: DATA_W];
  assign w_rr_nxt      = (w_win_idx == ID_W'(NCLIENTS - 1)) ? '0 : w_win_idx + 1'b1;

  assign w_resp_id    = mem_resp_tag[MEM_TAG_W-1:TAG_W];
  assign w_id_ok      = {1'b0, w_resp_id} < (ID_W + 1)'(NCLIENTS);
  assign cl_resp_data = mem_resp_data;
  assign cl_resp_tag  = mem_resp_tag[TAG_W-1:0];

  always_comb begin
    w_state_nxt    = r_state;
    mem_cmd_valid  = 1'b0;
    mem_data_valid = 1'b0;
    cl_cmd_ready   = '0;
    cl_data_ready  = '0;
    cl_resp_valid  = '0;
    w_cmd_fire     = 1'b0;
    w_data_fire    = 1'b0;
    if (!reset) begin
      for (int i = 0; i < NCLIENTS; i++)
        cl_resp_valid[i] = mem_resp_valid && w_id_ok && (w_resp_id == ID_W'(i));
      case (r_state)
        IDLE: begin
          mem_cmd_valid = w_win_any;
          cl_cmd_ready[w_win_idx] = w_win_any && mem_cmd_ready;
          w_cmd_fire = w_win_any && mem_cmd_ready;
          if (w_cmd_fire && w_win_rw) w_state_nxt = WDATA;
        end
        WDATA: begin
          mem_data_valid = cl_data_valid[r_owner];
          cl_data_ready[r_owner] = mem_data_ready;
          w_data_fire = cl_data_valid[r_owner] && mem_data_ready;
          if (w_data_fire && r_beat_cnt == BW'(DATA_BEATS - 1)) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
      r_resp_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cmd_fire) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
        r_rr_ptr <= '0;
`else
        r_rr_ptr <= w_rr_nxt;
`endif
        if (w_win_rw) begin
          r_owner    <= w_win_idx;
          r_beat_cnt <= '0;
        end
      end
      if (w_data_fire) r_beat_cnt <= r_beat_cnt + 1'b1;
      if (mem_resp_valid && !w_id_ok) r_resp_err <= 1'b1;
    end
  end

  assign resp_err     = r_resp_err;
  assign o_dbg_state  = r_state;
  assign o_dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 2-client instance for arbitration, bursts and routing,
// plus a 3-client instance for the out-of-range response id.
module tb_mem_arbiter;

  localparam int N = 2, AW = 26, TW = 5, DW = 128, MTW = 6;
  localparam int N3 = 3, AW3 = 8, TW3 = 5, DW3 = 8, MTW3 = 7;
  localparam logic [AW-1:0] A0 = 26'h1234567, A1 = 26'h2FEDCBA;

  logic clk = 1'b0, reset = 1'b1;
  int checks = 0, errors = 0;

  logic [N-1:0] cl_cmd_valid = '0, cl_cmd_ready, cl_cmd_rw = '0;
  logic [N-1:0] cl_data_valid = '0, cl_data_ready, cl_resp_valid;
  logic [N*AW-1:0] cl_cmd_addr = '0;
  logic [N*TW-1:0] cl_cmd_tag = '0;
  logic [N*DW-1:0] cl_data_data = '0;
  logic [DW-1:0] cl_resp_data, mem_data_data, mem_resp_data = '0;
  logic [TW-1:0] cl_resp_tag;
  logic mem_cmd_valid, mem_cmd_ready = 1'b0, mem_cmd_rw, mem_data_valid, mem_data_ready = 1'b0;
  logic [AW-1:0] mem_cmd_addr;
  logic [MTW-1:0] mem_cmd_tag, mem_resp_tag = '0;
  logic mem_resp_valid = 1'b0, resp_err, dbg_state;
  logic [0:0] dbg_rr_ptr;

  logic [N3-1:0] t3_cmd_ready, t3_data_ready, t3_resp_valid;
  logic [DW3-1:0] t3_resp_data, t3_mem_data_data;
  logic [TW3-1:0] t3_resp_tag;
  logic t3_mem_cmd_valid, t3_mem_cmd_rw, t3_mem_data_valid, t3_resp_err, t3_dbg_state;
  logic [AW3-1:0] t3_mem_cmd_addr;
  logic [MTW3-1:0] t3_mem_cmd_tag, t3_mem_resp_tag = '0;
  logic t3_mem_resp_valid = 1'b0;
  logic [1:0] t3_dbg_rr_ptr;

  always #5 clk = ~clk;

  mem_arbiter #(.NCLIENTS(N), .ADDR_W(AW), .TAG_W(TW), .DATA_W(DW), .DATA_BEATS(4)) dut (
    .clk(clk), .reset(reset),
    .cl_cmd_valid(cl_cmd_valid), .cl_cmd_ready(cl_cmd_ready), .cl_cmd_addr(cl_cmd_addr),
    .cl_cmd_tag(cl_cmd_tag), .cl_cmd_rw(cl_cmd_rw),
    .cl_data_valid(cl_data_valid), .cl_data_ready(cl_data_ready), .cl_data_data(cl_data_data),
    .cl_resp_valid(cl_resp_valid), .cl_resp_data(cl_resp_data), .cl_resp_tag(cl_resp_tag),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_tag(mem_cmd_tag), .mem_cmd_rw(mem_cmd_rw),
    .mem_data_valid(mem_data_valid), .mem_data_ready(mem_data_ready), .mem_data_data(mem_data_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag),
    .resp_err(resp_err), .o_dbg_state(dbg_state), .o_dbg_rr_ptr(dbg_rr_ptr)
  );

  mem_arbiter #(.NCLIENTS(N3), .ADDR_W(AW3), .TAG_W(TW3), .DATA_W(DW3), .DATA_BEATS(2)) dut3 (
    .clk(clk), .reset(reset),
    .cl_cmd_valid('0), .cl_cmd_ready(t3_cmd_ready), .cl_cmd_addr('0),
    .cl_cmd_tag('0), .cl_cmd_rw('0),
    .cl_data_valid('0), .cl_data_ready(t3_data_ready), .cl_data_data('0),
    .cl_resp_valid(t3_resp_valid), .cl_resp_data(t3_resp_data), .cl_resp_tag(t3_resp_tag),
    .mem_cmd_valid(t3_mem_cmd_valid), .mem_cmd_ready(1'b1), .mem_cmd_addr(t3_mem_cmd_addr),
    .mem_cmd_tag(t3_mem_cmd_tag), .mem_cmd_rw(t3_mem_cmd_rw),
    .mem_data_valid(t3_mem_data_valid), .mem_data_ready(1'b1), .mem_data_data(t3_mem_data_data),
    .mem_resp_valid(t3_mem_resp_valid), .mem_resp_data(8'h5A), .mem_resp_tag(t3_mem_resp_tag),
    .resp_err(t3_resp_err), .o_dbg_state(t3_dbg_state), .o_dbg_rr_ptr(t3_dbg_rr_ptr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    cl_cmd_valid = 2'b11; mem_cmd_ready = 1'b1; cl_data_valid = 2'b11; mem_data_ready = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_tag = 6'h21;
    #1;
    checks++; if (mem_cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_cmd_valid: got %b want 0", mem_cmd_valid); end
    checks++; if (cl_cmd_ready !== 2'b00) begin errors++; $display("FAIL rst_cl_cmd_ready: got %b want 00", cl_cmd_ready); end
    checks++; if (cl_data_ready !== 2'b00 || mem_data_valid !== 1'b0) begin errors++; $display("FAIL rst_data: got ready %b valid %b want 00 0", cl_data_ready, mem_data_valid); end
    checks++; if (cl_resp_valid !== 2'b00) begin errors++; $display("FAIL rst_resp_valid: got %b want 00", cl_resp_valid); end
    checks++; if (dbg_state !== 1'b0 || dbg_rr_ptr !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("FAIL rst_regs: got state %b ptr %b err %b want 0 0 0", dbg_state, dbg_rr_ptr, resp_err); end
    cl_cmd_valid = '0; mem_cmd_ready = 1'b0; cl_data_valid = '0; mem_data_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_tag = '0;
    step();
    reset = 1'b0;
    cl_cmd_addr = {A1, A0}; cl_cmd_tag = {5'h11, 5'h03};
  endtask

  task automatic test_fair_reads();
    logic [MTW-1:0] exp_tag;
    logic [AW-1:0] exp_addr;
    logic [N-1:0] exp_rdy;
    cl_cmd_valid = 2'b11; cl_cmd_rw = 2'b00; mem_cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_tag  = (i % 2 == 0) ? 6'h03 : 6'h31;
      exp_addr = (i % 2 == 0) ? A0 : A1;
      exp_rdy  = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++; if (cl_cmd_ready !== exp_rdy) begin errors++; $display("FAIL fair_ready[%0d]: got %b want %b", i, cl_cmd_ready, exp_rdy); end
      checks++; if (mem_cmd_tag !== exp_tag || mem_cmd_addr !== exp_addr) begin errors++; $display("FAIL fair_fields[%0d]: got tag %h addr %h want %h %h", i, mem_cmd_tag, mem_cmd_addr, exp_tag, exp_addr); end
      checks++; if (mem_cmd_valid !== 1'b1 || mem_cmd_rw !== 1'b0) begin errors++; $display("FAIL fair_valid[%0d]: got v %b rw %b want 1 0", i, mem_cmd_valid, mem_cmd_rw); end
      step();
    end
    cl_cmd_valid = '0; mem_cmd_ready = 1'b0;
  endtask

  task automatic test_stall();
    cl_cmd_valid = 2'b11; mem_cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (mem_cmd_valid !== 1'b1 || mem_cmd_tag !== 6'h03 || mem_cmd_addr !== A0) begin errors++; $display("FAIL stall_hold[%0d]: got v %b tag %h addr %h want 1 03 %h", i, mem_cmd_valid, mem_cmd_tag, mem_cmd_addr, A0); end
      checks++; if (cl_cmd_ready !== 2'b00 || dbg_rr_ptr !== 1'b0) begin errors++; $display("FAIL stall_ptr[%0d]: got ready %b ptr %b want 00 0", i, cl_cmd_ready, dbg_rr_ptr); end
      step();
    end
    mem_cmd_ready = 1'b1;
    #1;
    checks++; if (cl_cmd_ready !== 2'b01) begin errors++; $display("FAIL stall_release: got %b want 01", cl_cmd_ready); end
    step();
    cl_cmd_valid = '0; mem_cmd_ready = 1'b0;
    #1;
    checks++; if (dbg_rr_ptr !== 1'b1) begin errors++; $display("FAIL stall_ptr_adv: got %b want 1", dbg_rr_ptr); end
  endtask

  task automatic test_write_lock();
    logic [DW-1:0] beat;
    cl_cmd_valid = 2'b11; cl_cmd_rw = 2'b10; mem_cmd_ready = 1'b1; mem_data_ready = 1'b1;
    cl_data_valid = 2'b10; cl_data_data = {128'hD000_0000, 128'h0BAD};
    #1;
    checks++; if (cl_cmd_ready !== 2'b10 || mem_cmd_rw !== 1'b1 || mem_cmd_tag !== 6'h31) begin errors++; $display("FAIL wr_grant: got ready %b rw %b tag %h want 10 1 31", cl_cmd_ready, mem_cmd_rw, mem_cmd_tag); end
    checks++; if (cl_data_ready !== 2'b00 || mem_data_valid !== 1'b0) begin errors++; $display("FAIL wr_early_data: got ready %b valid %b want 00 0", cl_data_ready, mem_data_valid); end
    step();
    cl_cmd_valid = 2'b01; cl_cmd_rw = 2'b00;
    for (int b = 0; b < 4; b++) begin
      beat = 128'hD000_0000 + 128'(b);
      cl_data_data = {beat, 128'h0BAD};
      if (b == 2) begin
        mem_data_ready = 1'b0;
        #1;
        checks++; if (cl_data_ready !== 2'b00 || mem_data_valid !== 1'b1 || dbg_state !== 1'b1) begin errors++; $display("FAIL wr_data_stall: got ready %b valid %b state %b want 00 1 1", cl_data_ready, mem_data_valid, dbg_state); end
        step();
        mem_data_ready = 1'b1;
      end
      #1;
      checks++; if (mem_data_data !== beat || cl_data_ready !== 2'b10 || mem_data_valid !== 1'b1) begin errors++; $display("FAIL wr_beat[%0d]: got data %h ready %b valid %b want %h 10 1", b, mem_data_data, cl_data_ready, mem_data_valid, beat); end
      checks++; if (mem_cmd_valid !== 1'b0 || cl_cmd_ready !== 2'b00) begin errors++; $display("FAIL wr_cmd_block[%0d]: got v %b ready %b want 0 00", b, mem_cmd_valid, cl_cmd_ready); end
      step();
    end
    #1;
    checks++; if (dbg_state !== 1'b0 || cl_cmd_ready !== 2'b01 || mem_cmd_tag !== 6'h03) begin errors++; $display("FAIL wr_after: got state %b ready %b tag %h want 0 01 03", dbg_state, cl_cmd_ready, mem_cmd_tag); end
    checks++; if (cl_data_ready !== 2'b00 || mem_data_valid !== 1'b0) begin errors++; $display("FAIL wr_after_data: got ready %b valid %b want 00 0", cl_data_ready, mem_data_valid); end
    step();
    cl_cmd_valid = '0; cl_data_valid = '0; mem_cmd_ready = 1'b0; mem_data_ready = 1'b0;
  endtask

  task automatic test_resp_routing();
    cl_cmd_valid = 2'b01; mem_cmd_ready = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_tag = 6'h33; mem_resp_data = 128'hCAFE_F00D;
    #1;
    checks++; if (cl_resp_valid !== 2'b10 || cl_resp_tag !== 5'h13 || cl_resp_data !== 128'hCAFE_F00D) begin errors++; $display("FAIL resp_c1: got v %b tag %h data %h want 10 13 cafef00d", cl_resp_valid, cl_resp_tag, cl_resp_data); end
    checks++; if (cl_cmd_ready !== 2'b01) begin errors++; $display("FAIL resp_with_cmd: got %b want 01", cl_cmd_ready); end
    step();
    cl_cmd_valid = '0; mem_cmd_ready = 1'b0; mem_resp_tag = 6'h07;
    #1;
    checks++; if (cl_resp_valid !== 2'b01 || cl_resp_tag !== 5'h07) begin errors++; $display("FAIL resp_c0: got v %b tag %h want 01 07", cl_resp_valid, cl_resp_tag); end
    step();
    mem_resp_valid = 1'b0;
    t3_mem_resp_valid = 1'b1; t3_mem_resp_tag = 7'h73;
    #1;
    checks++; if (cl_resp_valid !== 2'b00 || resp_err !== 1'b0) begin errors++; $display("FAIL resp_idle: got v %b err %b want 00 0", cl_resp_valid, resp_err); end
    checks++; if (t3_resp_valid !== 3'b000 || t3_resp_err !== 1'b0) begin errors++; $display("FAIL resp3_bad_id: got v %b err %b want 000 0", t3_resp_valid, t3_resp_err); end
    step();
    t3_mem_resp_tag = 7'h41;
    #1;
    checks++; if (t3_resp_err !== 1'b1 || t3_resp_valid !== 3'b100 || t3_resp_tag !== 5'h01) begin errors++; $display("FAIL resp3_c2: got err %b v %b tag %h want 1 100 01", t3_resp_err, t3_resp_valid, t3_resp_tag); end
    step();
    t3_mem_resp_valid = 1'b0;
    #1;
    checks++; if (t3_resp_err !== 1'b1) begin errors++; $display("FAIL resp3_sticky: got %b want 1", t3_resp_err); end
  endtask

  task automatic test_reset_mid_burst();
    cl_cmd_valid = 2'b10; cl_cmd_rw = 2'b10; mem_cmd_ready = 1'b1;
    cl_data_valid = 2'b10; mem_data_ready = 1'b1;
    step();
    cl_cmd_valid = '0; cl_cmd_rw = '0;
    step();
    step();
    #1;
    checks++; if (dbg_state !== 1'b1 || cl_data_ready !== 2'b10) begin errors++; $display("FAIL mid_burst_state: got state %b ready %b want 1 10", dbg_state, cl_data_ready); end
    reset = 1'b1;
    #1;
    checks++; if (cl_data_ready !== 2'b00 || mem_data_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_force: got ready %b valid %b want 00 0", cl_data_ready, mem_data_valid); end
    step();
    reset = 1'b0; cl_cmd_valid = 2'b01;
    #1;
    checks++; if (dbg_state !== 1'b0 || dbg_rr_ptr !== 1'b0 || cl_data_ready !== 2'b00 || mem_data_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_idle: got state %b ptr %b ready %b dv %b want 0 0 00 0", dbg_state, dbg_rr_ptr, cl_data_ready, mem_data_valid); end
    checks++; if (cl_cmd_ready !== 2'b01 || mem_cmd_tag !== 6'h03 || mem_cmd_valid !== 1'b1) begin errors++; $display("FAIL mid_rst_grant: got ready %b tag %h v %b want 01 03 1", cl_cmd_ready, mem_cmd_tag, mem_cmd_valid); end
    step();
    cl_cmd_valid = '0; cl_data_valid = '0; mem_cmd_ready = 1'b0; mem_data_ready = 1'b0;
  endtask

`ifdef MEM_ARBITER_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    cl_cmd_valid = 2'b11; cl_cmd_rw = 2'b00; mem_cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (cl_cmd_ready !== 2'b01 || mem_cmd_tag !== 6'h03 || dbg_rr_ptr !== 1'b0) begin errors++; $display("FAIL fixed_prio[%0d]: got ready %b tag %h ptr %b want 01 03 0", i, cl_cmd_ready, mem_cmd_tag, dbg_rr_ptr); end
      step();
    end
    cl_cmd_valid = '0; mem_cmd_ready = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_fair_reads();
    test_stall();
    test_write_lock();
    test_resp_routing();
`endif
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
